// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter serialising accelerator read/write requests onto one
// single-ported data memory, returning a one-cycle done/valid pulse per op.
module acc_mem_arbiter #(
   parameter int NUM_ACC        = 4,
   parameter int ADDR_W         = 16,
   parameter int RD_DATA_W      = 512,
   parameter int WR_DATA_W      = 32,
   parameter int MEM_RD_LATENCY = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_ACC-1:0]            acc_rd_en,
   input  logic [NUM_ACC*ADDR_W-1:0]     acc_rd_addr,
   input  logic [NUM_ACC-1:0]            acc_wr_en,
   input  logic [NUM_ACC*ADDR_W-1:0]     acc_wr_addr,
   input  logic [NUM_ACC*WR_DATA_W-1:0]  acc_wr_data,
   output logic [NUM_ACC-1:0]            acc_rd_valid,
   output logic [RD_DATA_W-1:0]          acc_rd_data,
   output logic [NUM_ACC-1:0]            acc_wr_done,
   input  logic                          cpu_stall,
   output logic                          mem_rd_en,
   output logic [ADDR_W-1:0]             mem_rd_addr,
   input  logic [RD_DATA_W-1:0]          mem_rd_data,
   output logic                          mem_wr_en,
   output logic [ADDR_W-1:0]             mem_wr_addr,
   output logic [WR_DATA_W-1:0]          mem_wr_data,
   output logic [1:0]                    dbg_state,
   output logic [$clog2(NUM_ACC)-1:0]    dbg_rr_ptr
);

   localparam int PW = $clog2(NUM_ACC);
   localparam int LW = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]          gnt_q, gnt_d;
   logic                   op_wr_q, op_wr_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [WR_DATA_W-1:0]   wdata_q, wdata_d;
   logic [LW-1:0]          lat_cnt_q, lat_cnt_d;
   logic [RD_DATA_W-1:0]   rd_data_q, rd_data_d;

   logic [NUM_ACC-1:0]     req;
   logic [NUM_ACC-1:0]     gnt_oh;
   logic                   found;
   logic [PW-1:0]          pick;
   logic [PW-1:0]          cand;
   int                     idx;

   assign req    = acc_rd_en | acc_wr_en;
   assign gnt_oh = {{(NUM_ACC-1){1'b0}}, 1'b1} << gnt_q;

   // First requester at or after rr_ptr, wrapping modulo NUM_ACC.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_ACC; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_ACC) idx = idx - NUM_ACC;
         cand = PW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_d        = gnt_q;
      op_wr_d      = op_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lat_cnt_d    = lat_cnt_q;
      rd_data_d    = rd_data_q;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      acc_rd_valid = '0;
      acc_wr_done  = '0;
      case (state_q)
         IDLE: begin
            if (!cpu_stall && found) begin
               gnt_d    = pick;
               op_wr_d  = acc_wr_en[pick];
               addr_d   = acc_wr_en[pick] ? acc_wr_addr[int'(pick)*ADDR_W +: ADDR_W]
                                          : acc_rd_addr[int'(pick)*ADDR_W +: ADDR_W];
               wdata_d  = acc_wr_data[int'(pick)*WR_DATA_W +: WR_DATA_W];
               rr_ptr_d = (pick == PW'(NUM_ACC-1)) ? '0 : pick + PW'(1);
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (!cpu_stall) begin
               if (op_wr_q) begin
                  mem_wr_en = 1'b1;
                  state_d   = RESP;
               end else begin
                  mem_rd_en = 1'b1;
                  lat_cnt_d = '0;
                  state_d   = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // The memory op is already issued, so cpu_stall is ignored here.
            if (lat_cnt_q == LW'(MEM_RD_LATENCY-1)) begin
               rd_data_d = mem_rd_data;
               state_d   = RESP;
            end else begin
               lat_cnt_d = lat_cnt_q + LW'(1);
            end
         end
         RESP: begin
            if (op_wr_q) acc_wr_done  = gnt_oh;
            else         acc_rd_valid = gnt_oh;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         lat_cnt_q <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_q     <= gnt_d;
         op_wr_q   <= op_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         lat_cnt_q <= lat_cnt_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign mem_rd_addr = addr_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_data = wdata_q;
   assign acc_rd_data = rd_data_q;
   assign dbg_state   = state_q;
   assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed bench for acc_mem_arbiter: cycle-exact latency checks plus a
// scoreboard of expected memory ops and accelerator responses.
module tb_acc_mem_arbiter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    acc_rd_en = '0;
   logic [63:0]   acc_rd_addr = '0;
   logic [3:0]    acc_wr_en = '0;
   logic [63:0]   acc_wr_addr = '0;
   logic [127:0]  acc_wr_data = '0;
   logic [3:0]    acc_rd_valid;
   logic [511:0]  acc_rd_data;
   logic [3:0]    acc_wr_done;
   logic          cpu_stall = 1'b0;
   logic          mem_rd_en;
   logic [15:0]   mem_rd_addr;
   logic [511:0]  mem_rd_data = '0;
   logic          mem_wr_en;
   logic [15:0]   mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic [1:0]    dbg_state;
   logic [1:0]    dbg_rr_ptr;

   int checks = 0;
   int errors = 0;

   logic [48:0]   exp_mem_q[$];
   logic [3:0]    exp_rsp_q[$];
   logic [511:0]  exp_line_q[$];

   acc_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
      .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
      .acc_rd_valid(acc_rd_valid), .acc_rd_data(acc_rd_data), .acc_wr_done(acc_wr_done),
      .cpu_stall(cpu_stall),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] line_for(input logic [15:0] a);
      if (a == 16'h1000) return {64{8'hA5}};
      return {16{a, ~a}};
   endfunction

   // Memory model with one cycle of read latency.
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= line_for(mem_rd_addr);

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push_wr(input logic [2:0] i, input logic [15:0] a, input logic [31:0] d);
      exp_mem_q.push_back({1'b1, a, d});
      exp_rsp_q.push_back({1'b1, i});
   endtask

   task automatic push_rd(input logic [2:0] i, input logic [15:0] a, input logic rsp);
      exp_mem_q.push_back({1'b0, a, 32'h0});
      if (rsp) begin
         exp_rsp_q.push_back({1'b0, i});
         exp_line_q.push_back(line_for(a));
      end
   endtask

   // Waits (bounded) for a response pulse on any accelerator in mask.
   task automatic wait_rsp(input logic [3:0] mask, input int budget);
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         smp();
         if (((acc_wr_done | acc_rd_valid) & mask) != 4'h0) seen = 1'b1;
         else cyc();
      end
      check("rsp_timeout", seen, 1'b1);
   endtask

   // Scoreboard monitor: pops expected memory ops and responses as they appear.
   always @(negedge clk) begin
      logic [48:0] e;
      logic [3:0]  r;
      logic [2:0]  who;
      if (rst_n) begin
         if (mem_wr_en || mem_rd_en) begin
            check("mem_one_strobe", mem_wr_en & mem_rd_en, 1'b0);
            if (exp_mem_q.size() == 0) begin
               check("mem_unexpected", 1'b1, 1'b0);
            end else begin
               e = exp_mem_q.pop_front();
               check("mem_op", mem_wr_en ? {1'b1, mem_wr_addr, mem_wr_data}
                                         : {1'b0, mem_rd_addr, 32'h0}, e);
            end
         end
         if ((acc_wr_done | acc_rd_valid) != 4'h0) begin
            check("rsp_onehot", $countones(acc_wr_done | acc_rd_valid), 1);
            who = 3'd0;
            for (int i = 0; i < 4; i++)
               if (acc_wr_done[i] || acc_rd_valid[i]) who = 3'(i);
            if (exp_rsp_q.size() == 0) begin
               check("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               r = exp_rsp_q.pop_front();
               check("rsp_order", {|acc_wr_done, who}, r);
               if (!r[3] && exp_line_q.size() != 0)
                  check("rsp_rd_line", acc_rd_data, exp_line_q.pop_front());
            end
         end
      end
   end

   initial begin
      int cnt;

      // Reset state
      cyc(); cyc(); smp();
      check("rst_state", dbg_state, 2'd0);
      check("rst_rr", dbg_rr_ptr, 2'd0);
      check("rst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
      check("rst_pulses", {acc_rd_valid, acc_wr_done}, 8'h00);
      check("rst_rd_data", acc_rd_data, 512'h0);
      check("rst_mem_addr", {mem_rd_addr, mem_wr_addr, mem_wr_data}, 64'h0);
      cyc(); rst_n = 1'b1;
      cyc();

      // Acc1 write 0x5000 <- 0x5: mem_wr_en at T+1, done at T+2 only
      acc_wr_en = 4'b0010;
      acc_wr_addr[1*16 +: 16] = 16'h5000;
      acc_wr_data[1*32 +: 32] = 32'h5;
      push_wr(3'd1, 16'h5000, 32'h5);
      smp(); check("wr_T_idle", dbg_state, 2'd0);
      cyc(); smp();
      check("wr_T1_strobe", {mem_wr_en, mem_wr_addr, mem_wr_data}, {1'b1, 16'h5000, 32'h5});
      check("wr_T1_nodone", acc_wr_done, 4'b0000);
      cyc(); smp();
      check("wr_T2_done", acc_wr_done, 4'b0010);
      cyc(); acc_wr_en = '0;
      smp(); check("wr_T3_nodone", acc_wr_done, 4'b0000);

      // Acc2 read 0x1000: mem_rd_en at T+1, valid at T+3 with A5 line
      cyc();
      acc_rd_en = 4'b0100;
      acc_rd_addr[2*16 +: 16] = 16'h1000;
      push_rd(3'd2, 16'h1000, 1'b1);
      smp();
      cyc(); smp();
      check("rd_T1_strobe", {mem_rd_en, mem_rd_addr}, {1'b1, 16'h1000});
      cyc(); smp();
      check("rd_T2_novalid", acc_rd_valid, 4'b0000);
      cyc(); smp();
      check("rd_T3_valid", acc_rd_valid, 4'b0100);
      check("rd_T3_data", acc_rd_data, {64{8'hA5}});
      cyc(); acc_rd_en = '0;
      cyc(); cyc(); smp();
      check("rd_data_hold", acc_rd_data, {64{8'hA5}});

      // Acc0 read and write together: write wins
      cyc();
      acc_rd_en = 4'b0001; acc_wr_en = 4'b0001;
      acc_rd_addr[0 +: 16] = 16'h2000;
      acc_wr_addr[0 +: 16] = 16'h2004;
      acc_wr_data[0 +: 32] = 32'hDEAD;
      push_wr(3'd0, 16'h2004, 32'hDEAD);
      wait_rsp(4'b0001, 10);
      check("both_wr_done", acc_wr_done, 4'b0001);
      check("both_no_rdv", acc_rd_valid, 4'b0000);
      cyc(); acc_rd_en = '0; acc_wr_en = '0;

      // cpu_stall for 5 cycles while acc3 requests
      cyc();
      cpu_stall = 1'b1;
      acc_wr_en = 4'b1000;
      acc_wr_addr[3*16 +: 16] = 16'h3000;
      acc_wr_data[3*32 +: 32] = 32'h33;
      push_wr(3'd3, 16'h3000, 32'h33);
      for (int i = 0; i < 5; i++) begin
         smp();
         check("stall_no_strobe", {mem_rd_en, mem_wr_en}, 2'b00);
         check("stall_idle", dbg_state, 2'd0);
         cyc();
      end
      cpu_stall = 1'b0;
      smp(); check("unstall_T_idle", dbg_state, 2'd0);
      cyc(); smp();
      check("unstall_T1_wr", mem_wr_en, 1'b1);
      wait_rsp(4'b1000, 10);
      check("stall_done", acc_wr_done, 4'b1000);
      cyc(); acc_wr_en = '0;

      // Reset during RD_WAIT drops the response
      cyc();
      acc_rd_en = 4'b0010;
      acc_rd_addr[1*16 +: 16] = 16'h1234;
      push_rd(3'd1, 16'h1234, 1'b0);
      smp();
      cyc(); smp(); check("rrst_issue", mem_rd_en, 1'b1);
      cyc(); rst_n = 1'b0; acc_rd_en = '0;
      smp(); check("rrst_in_wait", dbg_state, 2'd2);
      cyc(); smp();
      check("rrst_state", dbg_state, 2'd0);
      check("rrst_rr", dbg_rr_ptr, 2'd0);
      check("rrst_outs", {acc_rd_valid, acc_wr_done, mem_rd_en, mem_wr_en}, 10'h0);
      check("rrst_rd_data", acc_rd_data, 512'h0);
      cyc(); rst_n = 1'b1;

      // All four write continuously: grant order 0,1,2,3,0
      cyc();
      for (int i = 0; i < 4; i++) begin
         acc_wr_addr[i*16 +: 16] = 16'h4000 + 16'(i);
         acc_wr_data[i*32 +: 32] = 32'h100 + 32'(i);
      end
      for (int i = 0; i < 5; i++) push_wr(3'(i % 4), 16'h4000 + 16'(i % 4), 32'h100 + 32'(i % 4));
      acc_wr_en = 4'hF;
      cnt = 0;
      for (int n = 0; n < 40 && cnt < 5; n++) begin
         smp();
         if (acc_wr_done != 4'h0) cnt++;
         if (cnt < 5) cyc();
      end
      check("rr_done_count", cnt, 5);
      cyc(); acc_wr_en = '0;
      repeat (4) cyc();
      smp();
      check("end_mem_q_empty", exp_mem_q.size(), 0);
      check("end_rsp_q_empty", exp_rsp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
